// File: rtl/pc_redirect_if.sv
// Request and response bundle between the hazard/trap logic and the PC redirect controller.
interface pc_redirect_if #(
  parameter int unsigned XLEN = 32
);
  logic            stall_i;
  logic            trap_taken_i;
  logic [XLEN-1:0] trap_entry_i;
  logic            system_ret_i;
  logic [XLEN-1:0] system_retaddr_i;
  logic            je_i;
  logic [XLEN-1:0] jump_addr_i;
  logic            pc_stall_o;
  logic            pc_redirect_o;
  logic [XLEN-1:0] pc_target_o;
  logic            flush_if_o;
  logic            flush_id_o;
  logic            pending_o;

  modport master (
    output stall_i, trap_taken_i, trap_entry_i, system_ret_i, system_retaddr_i, je_i, jump_addr_i,
    input  pc_stall_o, pc_redirect_o, pc_target_o, flush_if_o, flush_id_o, pending_o
  );

  modport slave (
    input  stall_i, trap_taken_i, trap_entry_i, system_ret_i, system_retaddr_i, je_i, jump_addr_i,
    output pc_stall_o, pc_redirect_o, pc_target_o, flush_if_o, flush_id_o, pending_o
  );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// PC redirect controller: arbitrates trap/mret/jump redirects, buffers them across stalls
// and squashes the front-end pipeline registers after each redirect.
module pc_redirect_ctrl #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned BOOT_CYCLES  = 2,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic          clk_i,
  input logic          rst_ni,
  pc_redirect_if.slave bus
);

  typedef enum logic [1:0] {StBoot, StRun, StHold, StFlush} state_e;
  // Ordered so that a numerically larger class has higher priority.
  typedef enum logic [1:0] {ClsJump, ClsMret, ClsTrap} cls_e;

  localparam logic [XLEN-1:0] AlignMask = {{(XLEN-2){1'b1}}, 2'b00};

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  cls_e            pend_cls_q, pend_cls_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;

  logic            new_valid;
  cls_e            new_cls;
  logic [XLEN-1:0] new_tgt;
  logic            take_new;
  logic [XLEN-1:0] tgt;
  logic            pc_stall, pc_redirect, flush;

  always_comb begin
    new_valid = 1'b1;
    new_cls   = ClsJump;
    new_tgt   = bus.jump_addr_i;
    if (bus.trap_taken_i) begin
      new_cls = ClsTrap;
      new_tgt = bus.trap_entry_i;
    end else if (bus.system_ret_i) begin
      new_cls = ClsMret;
      new_tgt = bus.system_retaddr_i;
    end else if (!bus.je_i) begin
      new_valid = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_cls_d  = pend_cls_q;
    pend_tgt_d  = pend_tgt_q;
    pc_stall    = bus.stall_i;
    pc_redirect = 1'b0;
    flush       = 1'b0;
    tgt         = '0;
    take_new    = 1'b0;
    unique case (state_q)
      StBoot: begin
        pc_stall = 1'b1;
        if (cnt_q <= 4'd1) state_d = StRun;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StRun: begin
        if (new_valid) begin
          tgt = new_tgt;
          if (!bus.stall_i) begin
            pc_redirect = 1'b1;
            state_d     = StFlush;
            cnt_d       = 4'(FLUSH_CYCLES);
          end else begin
            pend_cls_d = new_cls;
            pend_tgt_d = new_tgt;
            state_d    = StHold;
          end
        end
      end
      StHold: begin
        // Equal priority lets the newer request win.
        take_new = new_valid && (new_cls >= pend_cls_q);
        tgt      = take_new ? new_tgt : pend_tgt_q;
        if (bus.stall_i) begin
          if (take_new) begin
            pend_cls_d = new_cls;
            pend_tgt_d = new_tgt;
          end
        end else begin
          pc_redirect = 1'b1;
          pend_cls_d  = ClsJump;
          pend_tgt_d  = '0;
          state_d     = StFlush;
          cnt_d       = 4'(FLUSH_CYCLES);
        end
      end
      StFlush: begin
        flush = 1'b1;
        // Jumps and mrets seen here come from the wrong path; only traps matter.
        if (bus.trap_taken_i) begin
          tgt = bus.trap_entry_i;
          if (!bus.stall_i) begin
            pc_redirect = 1'b1;
            cnt_d       = 4'(FLUSH_CYCLES);
          end else begin
            pend_cls_d = ClsTrap;
            pend_tgt_d = bus.trap_entry_i;
            state_d    = StHold;
          end
        end else if (cnt_q <= 4'd1) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StBoot;
      cnt_q      <= 4'(BOOT_CYCLES);
      pend_cls_q <= ClsJump;
      pend_tgt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_cls_q <= pend_cls_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  assign bus.pc_stall_o    = pc_stall;
  assign bus.pc_redirect_o = pc_redirect;
  assign bus.pc_target_o   = tgt & AlignMask;
  assign bus.flush_if_o    = flush;
  assign bus.flush_id_o    = flush;
  assign bus.pending_o     = (state_q == StHold);

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: directed vector table, async-reset sequences and random traffic
// checked against a cycle-level reference model.
module tb_pc_redirect_ctrl;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned BOOT  = 2;
  localparam int unsigned FLUSH = 2;
  localparam logic [36:0] RstExp = {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pc_redirect_if #(.XLEN(XLEN)) bus ();

  pc_redirect_ctrl #(
    .XLEN        (XLEN),
    .BOOT_CYCLES (BOOT),
    .FLUSH_CYCLES(FLUSH)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        stall;
    logic        trap;
    logic [31:0] ta;
    logic        ret;
    logic [31:0] ra;
    logic        je;
    logic [31:0] ja;
    logic        e_stall;
    logic        e_redir;
    logic [31:0] e_tgt;
    logic        e_flush;
    logic        e_pend;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state: cycles left in boot / flush, and the buffered redirect.
  int          m_boot, m_flush, m_prank;
  bit          m_pend;
  logic [31:0] m_paddr;

  function automatic vec_t mk(logic s, logic t, logic [31:0] ta, logic r, logic [31:0] ra,
                              logic j, logic [31:0] ja, logic es, logic er, logic [31:0] et,
                              logic ef, logic ep);
    vec_t v;
    v.stall = s;  v.trap = t;  v.ta = ta;  v.ret = r;  v.ra = ra;  v.je = j;  v.ja = ja;
    v.e_stall = es;  v.e_redir = er;  v.e_tgt = et;  v.e_flush = ef;  v.e_pend = ep;
    return v;
  endfunction

  function automatic logic [36:0] outs();
    return {bus.pc_stall_o, bus.pc_redirect_o, bus.pc_target_o, bus.flush_if_o, bus.flush_id_o,
            bus.pending_o};
  endfunction

  function automatic string fmt(logic [36:0] x);
    return $sformatf("stall=%0b redir=%0b tgt=%h fif=%0b fid=%0b pend=%0b",
                     x[36], x[35], x[34:3], x[2], x[1], x[0]);
  endfunction

  task automatic check(input string name, input logic [36:0] act, input logic [36:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %s, want %s", name, fmt(act), fmt(exp));
  endtask

  task automatic apply(input logic s, input logic t, input logic [31:0] ta, input logic r,
                       input logic [31:0] ra, input logic j, input logic [31:0] ja);
    bus.stall_i = s;  bus.trap_taken_i = t;  bus.trap_entry_i = ta;
    bus.system_ret_i = r;  bus.system_retaddr_i = ra;  bus.je_i = j;  bus.jump_addr_i = ja;
  endtask

  task automatic model_reset();
    m_boot = BOOT;  m_flush = 0;  m_pend = 0;  m_prank = 0;  m_paddr = '0;
  endtask

  // Expected outputs for the current inputs, then advance the model past the coming edge.
  task automatic model_cycle(output logic [36:0] exp);
    int          rank;
    logic [31:0] addr;
    if (m_boot > 0) begin
      exp = RstExp;
      m_boot--;
    end else begin
      rank = 0;
      addr = '0;
      if (bus.trap_taken_i) begin
        rank = 3;  addr = bus.trap_entry_i;
      end else if (m_flush == 0 && bus.system_ret_i) begin
        rank = 2;  addr = bus.system_retaddr_i;
      end else if (m_flush == 0 && bus.je_i) begin
        rank = 1;  addr = bus.jump_addr_i;
      end
      if (m_pend && rank < m_prank) begin
        rank = m_prank;  addr = m_paddr;
      end
      exp = {bus.stall_i, (rank > 0) && !bus.stall_i, (rank > 0) ? (addr & ~32'h3) : 32'h0,
             m_flush > 0, m_flush > 0, m_pend};
      if (rank > 0) begin
        if (bus.stall_i) begin
          m_pend = 1;  m_prank = rank;  m_paddr = addr;  m_flush = 0;
        end else begin
          m_pend = 0;  m_flush = FLUSH;
        end
      end else if (m_flush > 0) begin
        m_flush--;
      end
    end
  endtask

  task automatic mcycle(input string name);
    logic [36:0] e;
    #3;
    model_cycle(e);
    check(name, outs(), e);
    @(posedge clk);
    #1;
  endtask

  // Called late in a cycle: drop reset between edges, check, hold two edges, release.
  task automatic async_reset(input string name);
    #1 rst_n = 1'b0;
    #1 check(name, outs(), RstExp);
    model_reset();
    apply(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [36:0] e;
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,        1, 0, 32'h0,    0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,        1, 0, 32'h0,    0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,        0, 0, 32'h0,    0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h100,  0, 1, 32'h100,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,        0, 0, 32'h0,    1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,        0, 0, 32'h0,    1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,        0, 0, 32'h0,    0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 32'h200,  1, 0, 32'h200,  0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,        1, 0, 32'h200,  0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,        1, 0, 32'h200,  0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,        0, 1, 32'h200,  0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,        0, 0, 32'h0,    1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,        0, 0, 32'h0,    1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,        0, 0, 32'h0,    0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 32'h200,  1, 0, 32'h200,  0, 0));
    vecs.push_back(mk(1, 1, 32'h80, 0, 0, 0, 0,   1, 0, 32'h80,   0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 32'h300,  1, 0, 32'h80,   0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,        0, 1, 32'h80,   0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h400,  0, 0, 32'h0,    1, 0));
    vecs.push_back(mk(0, 1, 32'h80, 0, 0, 0, 0,   0, 1, 32'h80,   1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,        0, 0, 32'h0,    1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,        0, 0, 32'h0,    1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,        0, 0, 32'h0,    0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h1237, 1, 32'h500, 0, 1, 32'h1234, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,        0, 0, 32'h0,    1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,        0, 0, 32'h0,    1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,        0, 0, 32'h0,    0, 0));

    apply(0, 0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #2 check("reset_values", outs(), RstExp);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_held", outs(), RstExp);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      apply(vecs[i].stall, vecs[i].trap, vecs[i].ta, vecs[i].ret, vecs[i].ra, vecs[i].je,
            vecs[i].ja);
      #3;
      e = {vecs[i].e_stall, vecs[i].e_redir, vecs[i].e_tgt, vecs[i].e_flush, vecs[i].e_flush,
           vecs[i].e_pend};
      check($sformatf("vec%0d", i), outs(), e);
      @(posedge clk);
      #1;
    end

    // Reset while a jump is buffered in HOLD must discard it.
    apply(1, 0, 0, 0, 0, 1, 32'h200);
    #3 check("hold_enter", outs(), {1'b1, 1'b0, 32'h200, 3'b000});
    @(posedge clk);
    #1 apply(1, 0, 0, 0, 0, 0, 0);
    #3 check("hold_pending", outs(), {1'b1, 1'b0, 32'h200, 3'b001});
    async_reset("rst_in_hold");
    for (int i = 0; i < 4; i++) mcycle($sformatf("post_rst%0d", i));
    apply(0, 0, 0, 0, 0, 1, 32'h103);
    #3 check("align_103", outs(), {1'b1 & 1'b0, 1'b1, 32'h100, 3'b000});
    model_cycle(e);
    @(posedge clk);
    #1;

    for (int i = 0; i < 500; i++) begin
      apply($urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0, $urandom,
            $urandom_range(0, 4) == 0, $urandom, $urandom_range(0, 3) == 0, $urandom);
      #3;
      model_cycle(e);
      check($sformatf("rand%0d", i), outs(), e);
      if ($urandom_range(0, 59) == 0) begin
        async_reset($sformatf("rand_rst%0d", i));
      end else begin
        @(posedge clk);
        #1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pc_redirect_ctrl.md
PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 Parameter XLEN, 32, address width.
REQ-002 Parameter BOOT_CYCLES, 2, cycles the PC is held after reset release (legal 1..15).
REQ-003 Parameter FLUSH_CYCLES, 2, cycles flush is asserted after each redirect (legal 1..7).
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 rst_ni  input  1  reset; asynchronous, active-low.
REQ-006 stall_i  input  1  pipeline stall request from hazard logic.
REQ-007 trap_taken_i  input  1  trap/interrupt redirect request.
REQ-008 trap_entry_i  input  XLEN  trap target.
REQ-009 system_ret_i  input  1  mret redirect request.
REQ-010 system_retaddr_i  input  XLEN  mret target.
REQ-011 je_i  input  1  branch/jump redirect request.
REQ-012 jump_addr_i  input  XLEN  branch/jump target.
REQ-013 pc_stall_o  output  1  hold PC (drives program counter stall).
REQ-014 pc_redirect_o  output  1  load pc_target_o into PC this cycle (drives program counter jump enable; its trap/mret inputs tied 0).
REQ-015 pc_target_o  output  XLEN  selected redirect target.
REQ-016 flush_if_o  output  1  squash IF/ID register.
REQ-017 flush_id_o  output  1  squash ID/EX register.
REQ-018 pending_o  output  1  a redirect is buffered awaiting stall release.

Function
REQ-019 FSM states SHALL be BOOT, RUN, HOLD, FLUSH.
REQ-020 Request priority SHALL be trap > mret > jump; only the winner's target is used.
REQ-021 pc_target_o[1:0] SHALL always be 2'b00; upper bits come from the winning/pending target.
REQ-022 BOOT: pc_stall_o=1, all requests ignored; after BOOT_CYCLES cycles go to RUN.
REQ-023 RUN, stall_i=0, any request: pc_redirect_o=1 combinationally in the same cycle with winner target; next state FLUSH, flush counter loaded with FLUSH_CYCLES.
REQ-024 RUN, stall_i=1, any request: pc_redirect_o=0; winner captured into pending register (target + priority class); next state HOLD.
REQ-025 RUN, no request: pc_stall_o=stall_i, pc_redirect_o=0.
REQ-026 HOLD, stall_i=1: pc_stall_o=1; a new request of higher or equal priority than pending replaces it; lower priority is dropped.
REQ-027 HOLD, stall_i=0: pc_redirect_o=1, target = winner of pending vs any same-cycle request under REQ-020 rule (equal priority -> new request wins); pending cleared; next state FLUSH.
REQ-028 FLUSH: flush_if_o=flush_id_o=1; counter decrements each cycle; RUN when counter reaches 1 and decrements.
REQ-029 FLUSH: je_i and system_ret_i SHALL be ignored (wrong-path); trap_taken_i with stall_i=0 redirects immediately and reloads counter; trap_taken_i with stall_i=1 is captured and goes to HOLD.
REQ-030 pc_stall_o SHALL be 1 in BOOT, in HOLD while stall_i=1, and equal stall_i otherwise; pc_stall_o and pc_redirect_o SHALL never both be 1.
REQ-031 pending_o SHALL be 1 exactly in state HOLD.

Reset
REQ-032 rst_ni low SHALL immediately, without clock, force state BOOT, counters loaded, pending cleared.
REQ-033 Reset values: pc_stall_o=1, pc_redirect_o=0, pc_target_o=0, flush_if_o=0, flush_id_o=0, pending_o=0.
REQ-034 Reset asserted in HOLD or FLUSH SHALL discard the buffered redirect; no redirect is issued after release.

Verification
REQ-035 Release reset, no requests -> pc_stall_o=1 for exactly 2 cycles, then 0; no redirect.
REQ-036 RUN, je_i=1, jump_addr_i=0x100, stall_i=0 -> same cycle pc_redirect_o=1, pc_target_o=0x100; flush_if_o/flush_id_o=1 for next 2 cycles.
REQ-037 RUN, stall_i=1, je_i=1 to 0x200 for one cycle, stall held 3 cycles -> pending_o=1, pc_stall_o=1; on stall drop pc_redirect_o=1 with 0x200, pending_o=0.
REQ-038 HOLD with pending jump 0x200, trap_taken_i=1 to 0x80 during stall -> release redirects to 0x80; subsequent je_i 0x300 during stall ignored.
REQ-039 FLUSH, je_i=1 to 0x400 -> ignored; trap_taken_i=1 to 0x80 -> immediate redirect 0x80, flush extended 2 more cycles.
REQ-040 rst_ni low in HOLD with pending 0x200 -> outputs return to reset values asynchronously; after release no redirect to 0x200; jump_addr_i=0x103 later -> pc_target_o=0x100.
